// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter that hands the 16-slot IO bus to one requester at a time,
// sequences the slot decoder through ADDR/WAIT/DONE, and returns data or a timeout.
module io_bus_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [4*NUM_REQ-1:0]      req_addr,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [DATA_W*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        done,
  output logic                      err,
  output logic [DATA_W-1:0]         rdata,
  output logic [3:0]                io_addr,
  output logic                      io_addr_read,
  output logic                      io_we,
  output logic [DATA_W-1:0]         io_wdata,
  input  logic                      io_ack,
  input  logic [DATA_W-1:0]         io_rdata,
  output logic [1:0]                dbg_state_o
);

  localparam int IW = (NUM_REQ > 2) ? 2 : 1;
  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WAIT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [3:0]          io_addr_q, io_addr_d;
  logic                io_rd_q, io_rd_d;
  logic                io_we_q, io_we_d;
  logic [DATA_W-1:0]   io_wdata_q, io_wdata_d;
  logic [IW-1:0]       winner_q, winner_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [7:0]          cnt_q, cnt_d;

  logic                found;
  logic [IW-1:0]       pick;
  logic [3:0]          sel_addr;
  logic                sel_we;
  logic [DATA_W-1:0]   sel_wdata;

  // Round-robin search: first requesting index at or after ptr_q, wrapping.
  always_comb begin
    int j;
    found     = 1'b0;
    pick      = '0;
    sel_addr  = '0;
    sel_we    = 1'b0;
    sel_wdata = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req[IW'(j)]) begin
        found = 1'b1;
        pick  = IW'(j);
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick == IW'(k)) begin
        sel_addr  = req_addr[4*k +: 4];
        sel_we    = req_we[k];
        sel_wdata = req_wdata[DATA_W*k +: DATA_W];
      end
    end
  end

  // Outputs are registered, so each is loaded on the edge entering the state it belongs to.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    done_d     = '0;
    err_d      = err_q;
    rdata_d    = rdata_q;
    io_addr_d  = io_addr_q;
    io_rd_d    = io_rd_q;
    io_we_d    = io_we_q;
    io_wdata_d = io_wdata_q;
    winner_d   = winner_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d    = S_ADDR;
          winner_d   = pick;
          grant_d    = NUM_REQ'(1) << pick;
          io_rd_d    = 1'b1;
          io_addr_d  = sel_addr;
          io_we_d    = sel_we;
          io_wdata_d = sel_wdata;
        end
      end
      S_ADDR: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (io_ack || cnt_q == LAST_CNT) begin
          state_d = S_DONE;
          done_d  = grant_q;
          io_rd_d = 1'b0;
          io_we_d = 1'b0;
          err_d   = !io_ack;
          if (io_ack && !io_we_q) rdata_d = io_rdata;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d    = S_IDLE;
        grant_d    = '0;
        io_addr_d  = '0;
        io_wdata_d = '0;
        ptr_d      = (winner_q == IW'(NUM_REQ - 1)) ? '0 : winner_q + IW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      io_addr_q  <= '0;
      io_rd_q    <= 1'b0;
      io_we_q    <= 1'b0;
      io_wdata_q <= '0;
      winner_q   <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      io_addr_q  <= io_addr_d;
      io_rd_q    <= io_rd_d;
      io_we_q    <= io_we_d;
      io_wdata_q <= io_wdata_d;
      winner_q   <= winner_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign grant        = grant_q;
  assign done         = done_q;
  assign err          = err_q;
  assign rdata        = rdata_q;
  assign io_addr      = io_addr_q;
  assign io_addr_read = io_rd_q;
  assign io_we        = io_we_q;
  assign io_wdata     = io_wdata_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter: a vector table of single transactions plus
// hand-written contention and mid-transaction reset sequences.
module tb_io_bus_arbiter;

  localparam int NR = 2;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NR-1:0] req = '0;
  logic [4*NR-1:0] req_addr = '0;
  logic [NR-1:0] req_we = '0;
  logic [DW*NR-1:0] req_wdata = '0;
  logic [NR-1:0] grant, done;
  logic          err;
  logic [DW-1:0] rdata;
  logic [3:0]    io_addr;
  logic          io_addr_read, io_we;
  logic [DW-1:0] io_wdata;
  logic          io_ack = 1'b0;
  logic [DW-1:0] io_rdata = '0;
  logic [1:0]    dbg_state;

  io_bus_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_we(req_we),
    .req_wdata(req_wdata), .grant(grant), .done(done), .err(err), .rdata(rdata),
    .io_addr(io_addr), .io_addr_read(io_addr_read), .io_we(io_we),
    .io_wdata(io_wdata), .io_ack(io_ack), .io_rdata(io_rdata),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    int          r;
    logic [3:0]  addr;
    logic        we;
    logic [15:0] wdata;
    int          ack_at;       // WAIT cycle index in which ack is driven, -1 = never
    logic        ack_in_addr;  // drive a stray ack during the ADDR cycle
    logic        drop_early;   // release req right after grant
    logic [15:0] dev_rdata;
    logic [1:0]  exp_grant;
    logic        exp_err;
    logic [15:0] exp_rdata;
    int          exp_waits;
  } vec_t;

  vec_t vecs[6];
  logic [1:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_grant"}, grant, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_rd"}, io_addr_read, 0);
    chk({nm, "_addr"}, io_addr, 0);
    chk({nm, "_we"}, io_we, 0);
  endtask

  // driver: one complete transaction from request to the IDLE cycle after done
  task automatic run_txn(input vec_t v);
    int w;
    @(negedge clk);
    req_addr[4*v.r +: 4]   = v.addr;
    req_we[v.r]            = v.we;
    req_wdata[DW*v.r +: DW] = v.wdata;
    req[v.r]               = 1'b1;
    @(negedge clk);
    chk("addr_grant", grant, v.exp_grant);
    chk("addr_rd", io_addr_read, 1);
    chk("addr_addr", io_addr, v.addr);
    chk("addr_we", io_we, v.we);
    chk("addr_wdata", io_wdata, v.wdata);
    io_ack   = v.ack_in_addr;
    io_rdata = 16'h5555;
    if (v.drop_early) req[v.r] = 1'b0;
    req_addr  = ~req_addr;
    req_wdata = ~req_wdata;
    req_we    = ~req_we;
    @(negedge clk);
    w = 0;
    while (done == '0 && w < 60) begin
      chk("wait_rd", io_addr_read, 1);
      chk("wait_addr", io_addr, v.addr);
      chk("wait_we", io_we, v.we);
      chk("wait_wdata", io_wdata, v.wdata);
      io_ack   = (w == v.ack_at);
      io_rdata = v.dev_rdata;
      w++;
      @(negedge clk);
    end
    io_ack = 1'b0;
    chk("wait_cycles", w, v.exp_waits);
    chk("done_mask", done, v.exp_grant);
    chk("done_err", err, v.exp_err);
    chk("done_rdata", rdata, v.exp_rdata);
    chk("done_rd", io_addr_read, 0);
    chk("done_we", io_we, 0);
    chk("done_grant", grant, v.exp_grant);
    req = '0;
    @(negedge clk);
    chk_idle("post_idle");
  endtask

  initial begin
    int cyc;
    int n_done;
    logic [1:0] e;
    vec_t v;

    //          r  addr  we    wdata     ack ackA drop dev_rdata  grant  err  rdata     waits
    vecs[0] = '{0, 4'd5, 1'b0, 16'h0000, 0,  1'b0, 1'b0, 16'hBEEF, 2'b01, 1'b0, 16'hBEEF, 1};
    vecs[1] = '{1, 4'd12, 1'b1, 16'h1234, 2, 1'b0, 1'b0, 16'hDEAD, 2'b10, 1'b0, 16'hBEEF, 3};
    vecs[2] = '{0, 4'd3, 1'b0, 16'h00C3, -1, 1'b0, 1'b0, 16'h9999, 2'b01, 1'b1, 16'hBEEF, 15};
    vecs[3] = '{1, 4'd9, 1'b0, 16'h0000, 14, 1'b0, 1'b0, 16'hA5A5, 2'b10, 1'b0, 16'hA5A5, 15};
    vecs[4] = '{0, 4'd15, 1'b0, 16'h0042, 1, 1'b1, 1'b1, 16'h0F0F, 2'b01, 1'b0, 16'h0F0F, 2};
    vecs[5] = '{1, 4'd0, 1'b1, 16'hFFFF, 0,  1'b0, 1'b0, 16'h1111, 2'b10, 1'b0, 16'h0F0F, 1};

    repeat (2) @(negedge clk);
    chk_idle("reset");
    chk("reset_err", err, 0);
    chk("reset_rdata", rdata, 0);
    chk("reset_wdata", io_wdata, 0);
    chk("reset_state", dbg_state, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

    // Contention: both requesters held, device acks immediately.
    @(negedge clk);
    req_addr = {4'd2, 4'd1};
    req_we   = '0;
    req      = '1;
    io_ack   = 1'b1;
    io_rdata = 16'h7777;
    exp_q    = {2'b01, 2'b10, 2'b01, 2'b10};
    n_done = 0;
    cyc = 0;
    while (n_done < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      chk("onehot_grant", {31'd0, $onehot0(grant)}, 1);
      if (grant == '0 || done != '0) chk("rd_idle_done", io_addr_read, 0);
      if (done != '0) begin
        e = exp_q.pop_front();
        chk("rr_order", done, e);
        n_done++;
        if (n_done == 4) req = '0;
      end
    end
    io_ack = 1'b0;
    chk("rr_count", n_done, 4);
    chk("rr_rdata", rdata, 16'h7777);
    @(negedge clk);
    chk_idle("rr_idle");

    // Requester 0 completes so the pointer moves to 1, then requester 1 is reset mid-WAIT.
    v = '{0, 4'd6, 1'b0, 16'h0000, 0, 1'b0, 1'b0, 16'h2468, 2'b01, 1'b0, 16'h2468, 1};
    run_txn(v);
    @(negedge clk);
    req_addr[7:4] = 4'd8;
    req_we = '0;
    req[1] = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_rst_rd", io_addr_read, 1);
    chk("pre_rst_grant", grant, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    chk("async_rst_rdata", rdata, 0);
    chk("async_rst_wdata", io_wdata, 0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_done", done, 0);
    end
    rst_n = 1'b1;
    req_addr = {4'd8, 4'd11};
    req = '1;
    @(negedge clk);
    chk("post_rst_grant", grant, 2'b01);
    chk("post_rst_addr", io_addr, 4'd11);
    io_ack   = 1'b1;
    io_rdata = 16'h1357;
    repeat (2) @(negedge clk);
    chk("post_rst_done", done, 2'b01);
    chk("post_rst_rdata", rdata, 16'h1357);
    req = '0;
    io_ack = 1'b0;
    @(negedge clk);
    chk_idle("final_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
